rf_mp_sb: RTL and testbench

- Parametrised multi-port register file for the Decode stage; successor to the fixed 32x32, 2R/1W rf.
- Adds configurable width, depth and read/write port counts.
- Adds optional hardwired zero register, write-to-read bypass with defined port priority, and a per-register busy scoreboard (reserve at issue, release at writeback).
- Adds a synchronous bulk clear.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 49 ++++
 rtl/rf_mp_sb.sv | 105 ++++++++++
 tb/tb_rf_mp_sb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package rf_pkg;

    localparam int unsigned RF_WIDTH     = 32;
    localparam int unsigned RF_DEPTH     = 32;
    localparam int unsigned RF_AW        = 5;
    localparam int unsigned RF_MAX_DEPTH = 256;
    localparam int unsigned RF_CNT_W     = 9;

    typedef logic [RF_AW-1:0]    rf_sel_t;
    typedef logic [RF_WIDTH-1:0] rf_data_t;

    // Population count over a zero-extended busy vector of up to RF_MAX_DEPTH bits.
    function automatic logic [RF_CNT_W-1:0] popcount(input logic [RF_MAX_DEPTH-1:0] v);
        logic [RF_CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(RF_MAX_DEPTH); i++) begin
            n = n + RF_CNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: reserve at issue, release at writeback, registered busy count.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             rsv_en_i,
    input  logic [AW-1:0]    rsv_sel_i,
    input  logic [DEPTH-1:0] rel_i,
    output logic [DEPTH-1:0] busy_o,
    output logic [AW:0]      busy_cnt_o
);

    logic [DEPTH-1:0] busy_nxt;

    // Reserve beats release; clear beats both; register 0 stays idle when hardwired.
    always_comb begin
        busy_nxt = busy_o;
        for (int r = 0; r < int'(DEPTH); r++) begin
            if (rsv_en_i && (rsv_sel_i == AW'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if (rel_i[r]) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_nxt[0] = 1'b0;
        end
        if (clear_i) begin
            busy_nxt = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_o     <= '0;
            busy_cnt_o <= '0;
        end else begin
            busy_o     <= busy_nxt;
            busy_cnt_o <= (AW+1)'(popcount(RF_MAX_DEPTH'(busy_nxt)));
        end
    end

endmodule

// File: rtl/rf_mp_sb.sv
// Parametrised multi-port register file with write bypass, optional zero register and busy scoreboard.
module rf_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_RD*AW-1:0]    rd_sel_i,
    output logic [NUM_RD*WIDTH-1:0] rd_data_o,
    output logic [NUM_RD-1:0]       rd_busy_o,
    input  logic [NUM_WR-1:0]       wr_en_i,
    input  logic [NUM_WR*AW-1:0]    wr_sel_i,
    input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
    input  logic                    rsv_en_i,
    input  logic [AW-1:0]           rsv_sel_i,
    input  logic                    clear_i,
    output logic [AW:0]             busy_cnt_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] rel;
    logic [DEPTH-1:0] busy;

    // Ports commit in ascending order so the highest-indexed writer to a register lands last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem[r] <= '0;
            end
        end else if (clear_i) begin
            for (int r = 0; r < int'(DEPTH); r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if (wr_en_i[w] && !((ZERO_REG != 0) && (wr_sel_i[w*AW +: AW] == '0))) begin
                    mem[wr_sel_i[w*AW +: AW]] <= wr_data_i[w*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Any enabled write releases its destination in the scoreboard.
    always_comb begin
        rel = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (wr_en_i[w]) begin
                rel[wr_sel_i[w*AW +: AW]] = 1'b1;
            end
        end
    end

    // Read mux with bypass; a same-cycle writeback both forwards data and masks busy.
    always_comb begin : read_mux
        logic [AW-1:0]    sel;
        logic [WIDTH-1:0] data;
        logic             hit;
        logic             bsy;
        rd_data_o = '0;
        rd_busy_o = '0;
        sel       = '0;
        data      = '0;
        hit       = 1'b0;
        bsy       = 1'b0;
        for (int k = 0; k < int'(NUM_RD); k++) begin
            sel  = rd_sel_i[k*AW +: AW];
            data = mem[sel];
            hit  = 1'b0;
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if (wr_en_i[w] && (wr_sel_i[w*AW +: AW] == sel)) begin
                    data = wr_data_i[w*WIDTH +: WIDTH];
                    hit  = 1'b1;
                end
            end
            bsy = busy[sel] & ~hit;
            if (rst_i || ((ZERO_REG != 0) && (sel == '0))) begin
                data = '0;
                bsy  = 1'b0;
            end
            rd_data_o[k*WIDTH +: WIDTH] = data;
            rd_busy_o[k]                = bsy;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .rsv_en_i   (rsv_en_i),
        .rsv_sel_i  (rsv_sel_i),
        .rel_i      (rel),
        .busy_o     (busy),
        .busy_cnt_o (busy_cnt_o)
    );

endmodule

// File: tb/tb_rf_mp_sb.sv
// Drives two rf_mp_sb configurations with shared stimulus and checks both against reference models.
module tb_rf_mp_sb;

    logic       clk;
    logic       s_rst;
    logic [4:0] s_rd_sel [3];
    logic [1:0] s_wr_en;
    logic [4:0] s_wr_sel [2];
    logic [63:0] s_wr_data [2];
    logic       s_rsv_en;
    logic [4:0] s_rsv_sel;
    logic       s_clear;

    // Config A: defaults (32x32, 2R/2W, zero register)
    logic [9:0]  a_rd_sel;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [1:0]  a_wr_en;
    logic [9:0]  a_wr_sel;
    logic [63:0] a_wr_data;
    logic [5:0]  a_busy_cnt;

    // Config B: 64-bit x 16, 3R/1W, no zero register
    logic [11:0]  b_rd_sel;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [0:0]   b_wr_en;
    logic [3:0]   b_wr_sel;
    logic [63:0]  b_wr_data;
    logic [4:0]   b_busy_cnt;

    assign a_rd_sel  = {s_rd_sel[1], s_rd_sel[0]};
    assign a_wr_en   = s_wr_en;
    assign a_wr_sel  = {s_wr_sel[1], s_wr_sel[0]};
    assign a_wr_data = {s_wr_data[1][31:0], s_wr_data[0][31:0]};
    assign b_rd_sel  = {s_rd_sel[2][3:0], s_rd_sel[1][3:0], s_rd_sel[0][3:0]};
    assign b_wr_en   = s_wr_en[0];
    assign b_wr_sel  = s_wr_sel[0][3:0];
    assign b_wr_data = s_wr_data[0];

    rf_mp_sb dut_a (
        .clk_i      (clk),
        .rst_i      (s_rst),
        .rd_sel_i   (a_rd_sel),
        .rd_data_o  (a_rd_data),
        .rd_busy_o  (a_rd_busy),
        .wr_en_i    (a_wr_en),
        .wr_sel_i   (a_wr_sel),
        .wr_data_i  (a_wr_data),
        .rsv_en_i   (s_rsv_en),
        .rsv_sel_i  (s_rsv_sel),
        .clear_i    (s_clear),
        .busy_cnt_o (a_busy_cnt)
    );

    rf_mp_sb #(
        .WIDTH    (64),
        .DEPTH    (16),
        .NUM_RD   (3),
        .NUM_WR   (1),
        .ZERO_REG (0)
    ) dut_b (
        .clk_i      (clk),
        .rst_i      (s_rst),
        .rd_sel_i   (b_rd_sel),
        .rd_data_o  (b_rd_data),
        .rd_busy_o  (b_rd_busy),
        .wr_en_i    (b_wr_en),
        .wr_sel_i   (b_wr_sel),
        .wr_data_i  (b_wr_data),
        .rsv_en_i   (s_rsv_en),
        .rsv_sel_i  (s_rsv_sel[3:0]),
        .clear_i    (s_clear),
        .busy_cnt_o (b_busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q [$];

    // Reference model state, indexed by config
    logic [63:0] m_mem  [2][32];
    logic [31:0] m_busy [2];

    function automatic int depth_of(int c); return (c == 0) ? 32 : 16; endfunction
    function automatic int nwr_of(int c);   return (c == 0) ? 2 : 1;   endfunction
    function automatic int nrd_of(int c);   return (c == 0) ? 2 : 3;   endfunction
    function automatic bit zr_of(int c);    return (c == 0);           endfunction

    function automatic logic [63:0] fit(int c, logic [63:0] v);
        return (c == 0) ? {32'h0, v[31:0]} : v;
    endfunction

    function automatic int hits(int c, int s);
        int n;
        n = -1;
        for (int w = 0; w < nwr_of(c); w++) begin
            if (s_wr_en[w] && (int'(s_wr_sel[w]) % depth_of(c) == s)) n = w;
        end
        return n;
    endfunction

    function automatic logic [63:0] exp_data(int c, logic [4:0] sel);
        int s;
        int w;
        s = int'(sel) % depth_of(c);
        if (s_rst || (zr_of(c) && s == 0)) return 64'h0;
        w = hits(c, s);
        return (w >= 0) ? fit(c, s_wr_data[w]) : m_mem[c][s];
    endfunction

    function automatic logic [63:0] exp_busy(int c, logic [4:0] sel);
        int s;
        s = int'(sel) % depth_of(c);
        if (s_rst || (zr_of(c) && s == 0) || hits(c, s) >= 0) return 64'h0;
        return {63'h0, m_busy[c][s]};
    endfunction

    function automatic int mcount(int c);
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[c][r]);
        return n;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_busy[c] = '0;
            for (int r = 0; r < 32; r++) m_mem[c][r] = '0;
        end
    endtask

    // Applies one rising edge to both models from the currently driven inputs.
    task automatic model_update();
        if (s_rst || s_clear) begin
            model_reset();
        end else begin
            for (int c = 0; c < 2; c++) begin
                int D;
                int rs;
                D  = depth_of(c);
                rs = int'(s_rsv_sel) % D;
                for (int r = 0; r < D; r++) begin
                    int w;
                    w = hits(c, r);
                    if (w >= 0 && !(zr_of(c) && r == 0)) m_mem[c][r] = fit(c, s_wr_data[w]);
                    if (s_rsv_en && rs == r && !(zr_of(c) && r == 0)) m_busy[c][r] = 1'b1;
                    else if (w >= 0) m_busy[c][r] = 1'b0;
                end
            end
        end
    endtask

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic chk(input logic [63:0] obs);
        exp_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < nrd_of(c); k++) begin
                push($sformatf("cfg%0d rd_data%0d sel=%0d", c, k, s_rd_sel[k]), exp_data(c, s_rd_sel[k]));
                push($sformatf("cfg%0d rd_busy%0d sel=%0d", c, k, s_rd_sel[k]), exp_busy(c, s_rd_sel[k]));
            end
            push($sformatf("cfg%0d busy_cnt", c), 64'(mcount(c)));
        end
        for (int k = 0; k < 2; k++) begin
            chk(64'(a_rd_data[k*32 +: 32]));
            chk(64'(a_rd_busy[k]));
        end
        chk(64'(a_busy_cnt));
        for (int k = 0; k < 3; k++) begin
            chk(b_rd_data[k*64 +: 64]);
            chk(64'(b_rd_busy[k]));
        end
        chk(64'(b_busy_cnt));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        s_wr_en   = '0;
        s_rsv_en  = 1'b0;
        s_rsv_sel = '0;
        s_clear   = 1'b0;
        for (int w = 0; w < 2; w++) begin
            s_wr_sel[w]  = '0;
            s_wr_data[w] = '0;
        end
    endtask

    task automatic wr(input int port, input logic [4:0] sel, input logic [63:0] data);
        s_wr_en[port]   = 1'b1;
        s_wr_sel[port]  = sel;
        s_wr_data[port] = data;
    endtask

    task automatic rd(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2);
        s_rd_sel[0] = s0;
        s_rd_sel[1] = s1;
        s_rd_sel[2] = s2;
    endtask

    initial begin
        s_rst = 1'b1;
        idle();
        rd(5'd0, 5'd1, 5'd2);
        model_reset();
        @(negedge clk);
        step();                                 // reset state
        s_rst = 1'b0;
        step();

        // Reset mid-cycle discards an in-flight write and reserve
        wr(0, 5'd5, 64'hDEADBEEF);
        rd(5'd5, 5'd6, 5'd5);
        step();
        idle();
        step();
        wr(0, 5'd6, 64'h0BADF00D);
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd6;
        #2;
        s_rst = 1'b1;
        model_reset();
        step();
        s_rst = 1'b0;
        idle();
        step();

        // Synchronous clear overrides writes and reserves; bypass still visible
        wr(0, 5'd5, 64'hDEADBEEF);
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd4;
        step();
        idle();
        s_clear = 1'b1;
        wr(0, 5'd8, 64'h55AA55AA);
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd8;
        rd(5'd8, 5'd5, 5'd4);
        step();
        idle();
        step();

        // Bypass priority between write ports
        wr(0, 5'd7, 64'h11111111);
        wr(1, 5'd7, 64'h22222222);
        rd(5'd7, 5'd7, 5'd7);
        step();
        idle();
        step();

        // Zero register
        wr(0, 5'd0, 64'hFFFFFFFF);
        s_rsv_en = 1'b1;
        rd(5'd0, 5'd0, 5'd0);
        step();
        idle();
        step();

        // Scoreboard reserve and writeback release
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd3;
        rd(5'd3, 5'd3, 5'd3);
        step();
        idle();
        step();
        wr(1, 5'd3, 64'hA5A5A5A5);
        wr(0, 5'd3, 64'hA5A5A5A5);
        step();
        idle();
        step();

        // Reserve wins over a same-cycle write; data still stored
        wr(0, 5'd9, 64'h1234);
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd9;
        rd(5'd9, 5'd9, 5'd9);
        step();
        idle();
        step();
        s_rsv_en  = 1'b1;
        s_rsv_sel = 5'd9;
        step();
        idle();
        step();

        // Fill every register, then read each on every port
        s_clear = 1'b1;
        step();
        idle();
        for (int i = 0; i < 16; i++) begin
            wr(0, 5'(2*i), {32'hC0DE0000 | 32'(2*i), 32'h1000 + 32'(2*i)});
            wr(1, 5'(2*i + 1), {32'hC0DE0000 | 32'(2*i + 1), 32'h1000 + 32'(2*i + 1)});
            step();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'((i + 11) % 32), 5'((i + 5) % 32));
            step();
        end

        // Random mixed traffic
        for (int n = 0; n < 1000; n++) begin
            s_wr_en      = 2'($urandom_range(0, 3));
            s_wr_sel[0]  = 5'($urandom_range(0, 31));
            s_wr_sel[1]  = ($urandom_range(0, 3) == 0) ? s_wr_sel[0] : 5'($urandom_range(0, 31));
            s_wr_data[0] = {$urandom, $urandom};
            s_wr_data[1] = {$urandom, $urandom};
            s_rsv_en     = ($urandom_range(0, 1) == 0);
            s_rsv_sel    = ($urandom_range(0, 4) == 0) ? s_wr_sel[0] : 5'($urandom_range(0, 31));
            s_clear      = ($urandom_range(0, 79) == 0);
            for (int k = 0; k < 3; k++) begin
                s_rd_sel[k] = ($urandom_range(0, 2) == 0) ? s_wr_sel[$urandom_range(0, 1)]
                                                          : 5'($urandom_range(0, 31));
            end
            step();
        end

        idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
